// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state encoding and default error data for bram_arbiter
package bram_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin pick; on contention the requester not granted last wins
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  always_comb grant = &req ? ~last_grant : req[1];
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one BRAM controller port between two requesters
// with round-robin arbitration, a one-cycle turnaround and a watchdog timeout.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_mem_valid,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic        s_mem_ready,
  input  logic [31:0] s_mem_rdata,
  output logic        timeout_err
);
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t      state, state_nx;
  logic        grant, last_grant, arb_grant, busy, start, done, hit_to;
  logic [15:0] cnt;
  logic [31:0] rdata;
  rr_arb2 u_arb (
    .req        ({m1_mem_valid, m0_mem_valid}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );
  always_comb begin
    busy         = state == BUSY;
    start        = state == IDLE && (m0_mem_valid || m1_mem_valid);
    done         = busy && (s_mem_ready || cnt == LAST);
    hit_to       = done && !s_mem_ready;
    state_nx     = start ? BUSY : done ? TURN : busy ? BUSY : IDLE;
    s_mem_valid  = busy;
    s_mem_addr   = busy ? (grant ? m1_mem_addr : m0_mem_addr) : '0;
    s_mem_wdata  = busy ? (grant ? m1_mem_wdata : m0_mem_wdata) : '0;
    s_mem_wstrb  = busy ? (grant ? m1_mem_wstrb : m0_mem_wstrb) : '0;
    rdata        = s_mem_ready ? s_mem_rdata : ERR_DATA;
    m0_mem_ready = done && !grant;
    m1_mem_ready = done && grant;
    m0_mem_rdata = m0_mem_ready ? rdata : '0;
    m1_mem_rdata = m1_mem_ready ? rdata : '0;
  end
  // last_grant starts at 1 so m0 wins the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        grant <= arb_grant;
        cnt   <= '0;
      end else if (busy) cnt <= cnt + 16'd1;
      if (done) last_grant <= grant;
      if (hit_to) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed and random traffic against a BRAM target model with a scoreboard
module tb_bram_arbiter;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 0, reset_n = 0;
  logic        m0_mem_valid = 0, m1_mem_valid = 0;
  logic [31:0] m0_mem_addr = 0, m1_mem_addr = 0, m0_mem_wdata = 0, m1_mem_wdata = 0;
  logic [3:0]  m0_mem_wstrb = 0, m1_mem_wstrb = 0;
  logic        m0_mem_ready, m1_mem_ready, s_mem_valid, s_mem_ready, timeout_err;
  logic [31:0] m0_mem_rdata, m1_mem_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic        dead = 0;
  logic [1:0]  vcnt = 0;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] q0 [$], q1 [$];
  int          order [$];
  int          n_chk = 0, n_pass = 0;
  logic        prev_rdy = 0;

  bram_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_mem_valid(m0_mem_valid), .m0_mem_addr(m0_mem_addr), .m0_mem_wdata(m0_mem_wdata),
    .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_addr(m1_mem_addr), .m1_mem_wdata(m1_mem_wdata),
    .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_addr(s_mem_addr), .s_mem_wdata(s_mem_wdata),
    .s_mem_wstrb(s_mem_wstrb), .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // BRAM target: word[i]=i, answers on the third cycle of a held request
  initial for (int i = 0; i < 256; i++) begin
    mem[i] = i;
    shadow[i] = i;
  end
  assign s_mem_ready = s_mem_valid && vcnt == 2'd2 && !dead;
  assign s_mem_rdata = mem[s_mem_addr[9:2]];
  always @(posedge clk) begin
    vcnt <= (s_mem_valid && !s_mem_ready) ? vcnt + 2'd1 : 2'd0;
    if (s_mem_ready)
      for (int b = 0; b < 4; b++)
        if (s_mem_wstrb[b]) mem[s_mem_addr[9:2]][b*8 +: 8] <= s_mem_wdata[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // expected response: error data if the target is dead, else the word before this access
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] e;
    int wi;
    wi = int'(a[9:2]);
    e = dead ? ERR : shadow[wi];
    if (!dead) for (int b = 0; b < 4; b++) if (s[b]) shadow[wi][b*8 +: 8] = w[b*8 +: 8];
    if (p == 0) begin
      m0_mem_addr = a; m0_mem_wdata = w; m0_mem_wstrb = s; m0_mem_valid = 1; q0.push_back(e);
    end else begin
      m1_mem_addr = a; m1_mem_wdata = w; m1_mem_wstrb = s; m1_mem_valid = 1; q1.push_back(e);
    end
  endtask

  task automatic finish_req(input int p);
    int k;
    logic r;
    k = 0;
    r = 0;
    while (!r && k < 200) begin
      @(negedge clk);
      r = (p == 0) ? m0_mem_ready : m1_mem_ready;
      k++;
    end
    chk(p == 0 ? "m0_handshake" : "m1_handshake", {31'd0, r}, 32'd1);
    @(posedge clk);
    #1;
    if (p == 0) m0_mem_valid = 0; else m1_mem_valid = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 0;
    m0_mem_valid = 0;
    m1_mem_valid = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_rdy) chk("turn_gap", {31'd0, s_mem_valid}, 32'd0);
      if (m0_mem_ready || m1_mem_ready) chk("one_ready", {31'd0, m0_mem_ready & m1_mem_ready}, 32'd0);
      if (m0_mem_ready) begin
        if (q0.size() == 0) chk("m0_unexpected_ready", 32'd1, 32'd0);
        else chk("m0_rdata", m0_mem_rdata, q0.pop_front());
        chk("m1_rdata_idle", m1_mem_rdata, 32'd0);
        order.push_back(0);
      end
      if (m1_mem_ready) begin
        if (q1.size() == 0) chk("m1_unexpected_ready", 32'd1, 32'd0);
        else chk("m1_rdata", m1_mem_rdata, q1.pop_front());
        chk("m0_rdata_idle", m0_mem_rdata, 32'd0);
        order.push_back(1);
      end
    end
    prev_rdy = reset_n && (m0_mem_ready || m1_mem_ready);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_ready", {31'd0, m0_mem_ready}, 0);
    chk("rst_m1_ready", {31'd0, m1_mem_ready}, 0);
    chk("rst_m0_rdata", m0_mem_rdata, 0);
    chk("rst_m1_rdata", m1_mem_rdata, 0);
    chk("rst_s_valid", {31'd0, s_mem_valid}, 0);
    chk("rst_s_addr", s_mem_addr, 0);
    chk("rst_s_wdata", s_mem_wdata, 0);
    chk("rst_s_wstrb", {28'd0, s_mem_wstrb}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    @(negedge clk);
    reset_n = 1;

    // single read with 1-cycle arbitration latency
    @(posedge clk); #1;
    issue(0, 32'h10, 0, 0);
    @(negedge clk);
    chk("lat_idle", {31'd0, s_mem_valid}, 0);
    @(negedge clk);
    chk("lat_busy", {31'd0, s_mem_valid}, 1);
    chk("lat_addr", s_mem_addr, 32'h10);
    finish_req(0);

    // simultaneous requests after reset: m0 first
    pulse_reset();
    order.delete();
    @(posedge clk); #1;
    fork
      begin issue(0, 32'h10, 0, 0); finish_req(0); end
      begin issue(1, 32'h20, 0, 0); finish_req(1); end
    join
    chk("sim_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("sim_first", order[0], 0);
      chk("sim_second", order[1], 1);
    end

    // continuous contention alternates
    order.delete();
    fork
      for (int i = 0; i < 2; i++) begin @(posedge clk); #1; issue(0, 32'h40 + 4 * i, 0, 0); finish_req(0); end
      for (int i = 0; i < 2; i++) begin @(posedge clk); #1; issue(1, 32'h80 + 4 * i, 0, 0); finish_req(1); end
    join
    chk("alt_count", order.size(), 4);
    if (order.size() == 4) for (int i = 0; i < 4; i++) chk("alt_order", order[i], i % 2);

    // m1 write then m0 read back
    @(posedge clk); #1;
    issue(1, 32'h20, 32'h1234_5678, 4'hF);
    finish_req(1);
    @(posedge clk); #1;
    issue(0, 32'h20, 0, 0);
    finish_req(0);
    chk("wr_mem", mem[8], 32'h1234_5678);

    // watchdog with a dead target
    chk("to_before", {31'd0, timeout_err}, 0);
    dead = 1;
    @(posedge clk); #1;
    issue(0, 32'h10, 0, 0);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_mem_valid) n++;
      if (m0_mem_ready) break;
    end
    chk("to_busy_cycles", n, 8);
    @(posedge clk); #1;
    m0_mem_valid = 0;
    dead = 0;
    @(negedge clk);
    chk("to_sticky", {31'd0, timeout_err}, 1);
    @(posedge clk); #1;
    issue(1, 32'h24, 0, 0);
    finish_req(1);
    chk("to_sticky_after", {31'd0, timeout_err}, 1);

    // reset in the middle of a transaction
    @(posedge clk); #1;
    issue(0, 32'h14, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, s_mem_valid}, 1);
    #1;
    reset_n = 0;
    #1;
    chk("mid_s_valid", {31'd0, s_mem_valid}, 0);
    chk("mid_s_addr", s_mem_addr, 0);
    chk("mid_m0_ready", {31'd0, m0_mem_ready}, 0);
    chk("mid_timeout_err", {31'd0, timeout_err}, 0);
    m0_mem_valid = 0;
    q0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (m0_mem_ready || m1_mem_ready) n++;
    end
    chk("mid_no_ready", n, 0);
    @(posedge clk); #1;
    issue(0, 32'h14, 0, 0);
    finish_req(0);

    // random traffic on disjoint regions
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        issue(0, {22'd0, 8'($urandom_range(32, 47)), 2'b00}, $urandom,
              $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)));
        finish_req(0);
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        issue(1, {22'd0, 8'($urandom_range(48, 63)), 2'b00}, $urandom,
              $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)));
        finish_req(1);
      end
    join
    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 256, meaning: target-port cycles in BUSY before forced completion; legal range 2..65535.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, meaning: read data returned on timeout.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 m0_mem_valid / m1_mem_valid  input  1  requester N request.
REQ-006 m0_mem_addr / m1_mem_addr  input  32  requester N byte address.
REQ-007 m0_mem_wdata / m1_mem_wdata  input  32  requester N write data.
REQ-008 m0_mem_wstrb / m1_mem_wstrb  input  4  requester N byte enables; 0 means read.
REQ-009 m0_mem_ready / m1_mem_ready  output  1  requester N completion strobe.
REQ-010 m0_mem_rdata / m1_mem_rdata  output  32  requester N read data, valid while ready=1.
REQ-011 s_mem_valid  output  1  request to shared BRAM controller.
REQ-012 s_mem_addr / s_mem_wdata / s_mem_wstrb  output  32/32/4  forwarded request fields.
REQ-013 s_mem_ready  input  1  BRAM controller completion.
REQ-014 s_mem_rdata  input  32  BRAM controller read data.
REQ-015 timeout_err  output  1  sticky flag; set on any timeout, cleared only by reset.

Function
REQ-016 Protocol on all ports: requester holds valid, addr, wdata, wstrb stable until ready=1 for one cycle; requester drops valid in the cycle after ready.
REQ-017 State machine states: IDLE, BUSY, TURN.
REQ-018 IDLE: no valid -> stay; one valid -> latch grant to that requester, go BUSY; both valid -> grant requester not granted last, go BUSY.
REQ-019 last_grant register resets to 1 so m0 wins the first simultaneous request.
REQ-020 BUSY: s_mem_valid=1; s_mem_addr/wdata/wstrb combinationally muxed from granted requester; first s_mem_valid cycle is the cycle after request sampled in IDLE (1-cycle arbitration latency).
REQ-021 BUSY with s_mem_ready=1: granted mN_mem_ready=1 and mN_mem_rdata=s_mem_rdata in same cycle (combinational), update last_grant, go TURN.
REQ-022 TURN: s_mem_valid=0 for exactly one cycle so the BRAM controller returns to idle; then IDLE.
REQ-023 Non-granted requester: ready=0, rdata=0 at all times; its request waits, never dropped.
REQ-024 Watchdog: 16-bit counter cleared on IDLE->BUSY, increments each BUSY cycle; when count reaches TIMEOUT-1 with s_mem_ready=0 -> granted ready=1, rdata=ERR_DATA, timeout_err<=1, go TURN.
REQ-025 s_mem_ready and timeout in same cycle: s_mem_ready wins; normal data returned, timeout_err unchanged.
REQ-026 s_mem_ready outside BUSY is ignored; no requester ready asserted.
REQ-027 Granted requester dropping valid in BUSY (protocol violation): transaction still completes to target; ready pulse still issued.
REQ-028 Writes and reads arbitrate identically; wstrb passed unmodified.

Reset
REQ-029 reset_n=0 asynchronously forces: state=IDLE, last_grant=1, counter=0, timeout_err=0, s_mem_valid=0, s_mem_addr/wdata/wstrb=0, m0/m1 ready=0, rdata=0.
REQ-030 Reset mid-BUSY abandons the transaction; no ready pulse to either requester after release.
REQ-031 First grant possible in the first rising edge after reset_n deasserts.

Structure
REQ-032 Package bram_arb_pkg holds the state enum (IDLE, BUSY, TURN) and the ERR_DATA default constant.
REQ-033 One sub-module: rr_arb2, 2-way round-robin arbiter (inputs req[1:0], last_grant; output grant index); rest stays in bram_arbiter.

Verification
REQ-034 Target model: BRAM controller preloaded word[i]=i, ready 2 cycles after valid; check each scenario with assertions.
REQ-035 m0 reads 0x10 alone -> s_mem_valid 1 cycle after request; m0_mem_ready=1 with rdata 0x0000_0004; m1_mem_ready stays 0.
REQ-036 m0 reads 0x10, m1 reads 0x20 same cycle after reset -> m0 served first (0x4), TURN cycle with s_mem_valid=0, then m1 gets 0x8.
REQ-037 Both requesters continuously request for 4 transactions -> grants alternate m0,m1,m0,m1; no starvation.
REQ-038 m1 writes 0x1234_5678 wstrb=4'b1111 to 0x20, then m0 reads 0x20 -> rdata 0x1234_5678.
REQ-039 Target model never asserts ready, TIMEOUT=8 -> m0_mem_ready at 8th BUSY cycle, rdata 0xDEAD_BEEF, timeout_err=1 until reset.
REQ-040 reset_n pulsed low during BUSY -> all outputs 0 immediately; no ready pulse afterwards; new request served normally.
